// File: rtl/muldiv_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_pkg
// Shared definitions for the RV32M multiply/divide sequencer:
//   - funct3 encodings of the M-extension ops (MULDIV_*)
//   - MulDivState_t, the sequencer FSM state type (IDLE/ITER/FIXUP/DONE)
//   - helpers that report which source operands an op treats as signed
// No ports (package).
// -----------------------------------------------------------------------------
package muldiv_sequencer_pkg;

   localparam logic [2:0] MULDIV_MUL    = 3'b000;
   localparam logic [2:0] MULDIV_MULH   = 3'b001;
   localparam logic [2:0] MULDIV_MULHSU = 3'b010;
   localparam logic [2:0] MULDIV_MULHU  = 3'b011;
   localparam logic [2:0] MULDIV_DIV    = 3'b100;
   localparam logic [2:0] MULDIV_DIVU   = 3'b101;
   localparam logic [2:0] MULDIV_REM    = 3'b110;
   localparam logic [2:0] MULDIV_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ITER  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } MulDivState_t;

   // MUL only needs the low product word, which is identical for signed and
   // unsigned operands, so it is handled as unsigned (no negation needed).
   function automatic logic rs1_is_signed(input logic [2:0] funct3);
      return (funct3 == MULDIV_MULH) || (funct3 == MULDIV_MULHSU) ||
             (funct3 == MULDIV_DIV)  || (funct3 == MULDIV_REM);
   endfunction

   function automatic logic rs2_is_signed(input logic [2:0] funct3);
      return (funct3 == MULDIV_MULH) || (funct3 == MULDIV_DIV) ||
             (funct3 == MULDIV_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter_unit.sv
// -----------------------------------------------------------------------------
// muldiv_iter_unit
// Iterative radix-2 datapath shared by multiply and divide.
//   Multiply: accumulator {hi, lo} starts as {0, multiplier}; each step adds
//             the multiplicand into hi when lo[0] is set, then shifts right.
//   Divide:   accumulator {rem, quo} starts as {0, dividend}; each step shifts
//             left and does a restoring subtract of the divisor.
// After XLEN steps the accumulator holds the magnitude result; the fixup
// logic applies the sign and selects low/high word or quotient/remainder.
//
// Ports:
//   i_Clock, i_Reset_n  clock, asynchronous active-low reset
//   i_Load              latch magnitudes, op select and signs; init accumulator
//   i_Step              perform one iteration step
//   i_Is_Mul            1 = multiply, 0 = divide (sampled on i_Load)
//   i_Sel               funct3[1:0] of the op (sampled on i_Load)
//   i_Sign1, i_Sign2    effective operand signs (sampled on i_Load)
//   i_Mag1, i_Mag2      operand magnitudes (sampled on i_Load)
//   o_Result            sign-fixed, selected result (combinational)
// -----------------------------------------------------------------------------
module muldiv_iter_unit #(
   parameter int XLEN = 32
) (
   input  logic            i_Clock,
   input  logic            i_Reset_n,
   input  logic            i_Load,
   input  logic            i_Step,
   input  logic            i_Is_Mul,
   input  logic [1:0]      i_Sel,
   input  logic            i_Sign1,
   input  logic            i_Sign2,
   input  logic [XLEN-1:0] i_Mag1,
   input  logic [XLEN-1:0] i_Mag2,
   output logic [XLEN-1:0] o_Result
);

   logic [2*XLEN-1:0] acc_reg;
   logic [XLEN-1:0]   addend_reg;   // multiplicand (mul) or divisor (div)
   logic              is_mul_reg;
   logic [1:0]        sel_reg;
   logic              sign1_reg;
   logic              sign2_reg;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_rem;
   logic [XLEN:0]     div_trial;
   logic              div_fits;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] prod_fixed;
   logic [XLEN-1:0]   quo_mag;
   logic [XLEN-1:0]   rem_mag;

   always_comb begin
      // Multiply step: conditional add into the high half, keep the carry
      // and shift the whole 65-bit value right by one.
      mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                 (acc_reg[0] ? {1'b0, addend_reg} : '0);
      mul_next = {mul_sum, acc_reg[XLEN-1:1]};

      // Divide step: the shifted partial remainder can reach 2*divisor-1, so
      // it needs XLEN+1 bits; the difference then always fits in XLEN+1 bits
      // signed, and its top bit tells whether the subtract succeeded.
      div_rem   = acc_reg[2*XLEN-1:XLEN-1];
      div_trial = div_rem - {1'b0, addend_reg};
      div_fits  = ~div_trial[XLEN];
      div_next  = {(div_fits ? div_trial[XLEN-1:0] : div_rem[XLEN-1:0]),
                   acc_reg[XLEN-2:0], div_fits};
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         acc_reg    <= '0;
         addend_reg <= '0;
         is_mul_reg <= 1'b0;
         sel_reg    <= 2'b00;
         sign1_reg  <= 1'b0;
         sign2_reg  <= 1'b0;
      end else if (i_Load) begin
         acc_reg    <= {{XLEN{1'b0}}, (i_Is_Mul ? i_Mag2 : i_Mag1)};
         addend_reg <= i_Is_Mul ? i_Mag1 : i_Mag2;
         is_mul_reg <= i_Is_Mul;
         sel_reg    <= i_Sel;
         sign1_reg  <= i_Sign1;
         sign2_reg  <= i_Sign2;
      end else if (i_Step) begin
         acc_reg <= is_mul_reg ? mul_next : div_next;
      end
   end

   // Sign fixup and result select
   always_comb begin
      prod_fixed = (sign1_reg ^ sign2_reg) ? -acc_reg : acc_reg;
      quo_mag    = acc_reg[XLEN-1:0];
      rem_mag    = acc_reg[2*XLEN-1:XLEN];
      o_Result   = '0;
      if (is_mul_reg) begin
         o_Result = (sel_reg == 2'b00) ? prod_fixed[XLEN-1:0]
                                       : prod_fixed[2*XLEN-1:XLEN];
      end else if (sel_reg[1]) begin
         // remainder follows the dividend's sign
         o_Result = sign1_reg ? -rem_mag : rem_mag;
      end else begin
         o_Result = (sign1_reg ^ sign2_reg) ? -quo_mag : quo_mag;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Sequences the shared iterative multiply/divide unit for RV32M ops in EX.
// Accepts one op at a time, stalls the pipeline while it iterates, and
// presents the result with a one-cycle o_Done pulse.
//
// Configuration macro: MULDIV_FAST_MUL_EN
//   defined   - multiplies use a single-cycle signed multiplier and finish
//               one cycle after accept
//   undefined - multiplies iterate like divides
//
// Ports:
//   i_Clock     clock
//   i_Reset_n   asynchronous active-low reset
//   i_Start     M-op present in EX (held until o_Done)
//   i_Funct3    op select (MUL..REMU)
//   i_Operand1  rs1 value
//   i_Operand2  rs2 value
//   i_Flush     squash any in-flight op
//   o_Stall     hold PC/IF/ID/EX registers
//   o_Done      o_Result valid this cycle
//   o_Result    selected result (held until the next DONE)
// -----------------------------------------------------------------------------
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ITERATIONS = 32
) (
   input  logic            i_Clock,
   input  logic            i_Reset_n,
   input  logic            i_Start,
   input  logic [2:0]      i_Funct3,
   input  logic [XLEN-1:0] i_Operand1,
   input  logic [XLEN-1:0] i_Operand2,
   input  logic            i_Flush,
   output logic            o_Stall,
   output logic            o_Done,
   output logic [XLEN-1:0] o_Result
);

   localparam int CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

   MulDivState_t      state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg;
   logic [XLEN-1:0]   result_reg;

   logic              accept;
   logic              step;
   logic              finish;

   logic              is_div;
   logic              want_rem;
   logic              sign1, sign2;
   logic [XLEN-1:0]   mag1, mag2;
   logic              div_by_zero;
   logic              div_ovf;
   logic              special;
   logic [XLEN-1:0]   special_result;
   logic              short_path;
   logic [XLEN-1:0]   short_result;
   logic [XLEN-1:0]   unit_result;

   // ---------------- operand conditioning / special cases ----------------
   assign is_div   = i_Funct3[2];
   assign want_rem = i_Funct3[1];
   assign sign1    = rs1_is_signed(i_Funct3) & i_Operand1[XLEN-1];
   assign sign2    = rs2_is_signed(i_Funct3) & i_Operand2[XLEN-1];
   assign mag1     = sign1 ? -i_Operand1 : i_Operand1;
   assign mag2     = sign2 ? -i_Operand2 : i_Operand2;

   assign div_by_zero = is_div & (i_Operand2 == '0);
   // funct3[0]=0 selects the signed divide ops (DIV/REM)
   assign div_ovf     = is_div & ~i_Funct3[0] &
                        (i_Operand1 == {1'b1, {(XLEN-1){1'b0}}}) &
                        (i_Operand2 == '1);
   assign special     = div_by_zero | div_ovf;

   always_comb begin
      special_result = '0;
      if (div_by_zero) begin
         special_result = want_rem ? i_Operand1 : '1;
      end else begin
         special_result = want_rem ? '0 : i_Operand1;
      end
   end

`ifdef MULDIV_FAST_MUL_EN
   // Operands are extended to the full product width (signed per op), which
   // yields the same low 2*XLEN bits as an (XLEN+1)x(XLEN+1) signed multiply.
   logic [2*XLEN-1:0] fast_op1, fast_op2, fast_prod;
   logic [XLEN-1:0]   fast_result;

   assign fast_op1    = {{XLEN{rs1_is_signed(i_Funct3) & i_Operand1[XLEN-1]}}, i_Operand1};
   assign fast_op2    = {{XLEN{rs2_is_signed(i_Funct3) & i_Operand2[XLEN-1]}}, i_Operand2};
   assign fast_prod   = fast_op1 * fast_op2;
   assign fast_result = (i_Funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                 : fast_prod[2*XLEN-1:XLEN];
   assign short_path   = special | ~is_div;
   assign short_result = is_div ? special_result : fast_result;
`else
   assign short_path   = special;
   assign short_result = special_result;
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      o_Done     = 1'b0;
      o_Stall    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_Start && !i_Flush) begin
               accept     = 1'b1;
               state_next = short_path ? DONE : ITER;
            end
         end
         ITER: begin
            step = ~i_Flush;
            if (cnt_reg == '0) begin
               state_next = FIXUP;
            end
         end
         FIXUP: begin
            finish     = ~i_Flush;
            state_next = DONE;
         end
         DONE: begin
            // i_Start is still high for the retiring op; it is ignored here
            o_Done     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (i_Flush) begin
         state_next = IDLE;
      end
      // Stall is forced low while reset is held, even if i_Start is high
      o_Stall = i_Reset_n & (accept | (state_reg == ITER) | (state_reg == FIXUP));
   end

   // ---------------- iteration counter ----------------
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         cnt_reg <= '0;
      end else if (accept) begin
         cnt_reg <= CNT_W'(ITERATIONS - 1);
      end else if (step) begin
         cnt_reg <= cnt_reg - CNT_W'(1);
      end
   end

   // ---------------- result register ----------------
   // Updated only on the way into DONE, so it holds across flushes.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         result_reg <= '0;
      end else if (accept && short_path) begin
         result_reg <= short_result;
      end else if (finish) begin
         result_reg <= unit_result;
      end
   end

   assign o_Result = result_reg;

   muldiv_iter_unit #(
      .XLEN (XLEN)
   ) u_iter_unit (
      .i_Clock   (i_Clock),
      .i_Reset_n (i_Reset_n),
      .i_Load    (accept & ~short_path),
      .i_Step    (step),
      .i_Is_Mul  (~is_div),
      .i_Sel     (i_Funct3[1:0]),
      .i_Sign1   (sign1),
      .i_Sign2   (sign2),
      .i_Mag1    (mag1),
      .i_Mag2    (mag2),
      .o_Result  (unit_result)
   );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Table-driven vectors plus hand-written sequences for flush, asynchronous
// reset mid-op and back-to-back issue. Expected results and completion cycles
// are pushed to a scoreboard when an op is driven; a monitor pops and
// compares them on each o_Done pulse.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 34;
`endif
   localparam int DIV_LAT = 34;
   localparam int NVEC    = 22;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  f = 3'b000;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        stall;
   logic        done;
   logic [31:0] res;

   always #5 clk = ~clk;

   muldiv_sequencer #(
      .XLEN       (32),
      .ITERATIONS (32)
   ) dut (
      .i_Clock    (clk),
      .i_Reset_n  (rst_n),
      .i_Start    (start),
      .i_Funct3   (f),
      .i_Operand1 (a),
      .i_Operand2 (b),
      .i_Flush    (flush),
      .o_Stall    (stall),
      .o_Done     (done),
      .o_Result   (res)
   );

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] exp;
      int          due;
      int          id;
   } sb_t;

   sb_t  sb_q[$];
   vec_t tbl[NVEC];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   op_id = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: one pop per o_Done pulse
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got o_Done=1 at cycle %0d want no pulse", cyc);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            total += 2;
            if (res !== e.exp) begin
               bad++;
               $display("FAIL op%0d result: got %h want %h", e.id, res, e.exp);
            end
            if (cyc != e.due) begin
               bad++;
               $display("FAIL op%0d done_cycle: got %0d want %0d", e.id, cyc, e.due);
            end
            $display("op%0d done cycle=%0d result=%h", e.id, cyc, res);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic push_exp(input logic [31:0] exp, input int due);
      sb_t e;
      e.exp = exp;
      e.due = due;
      e.id  = op_id;
      op_id++;
      sb_q.push_back(e);
   endtask

   // Called at negedge+1; returns in the DONE cycle (or after the bound)
   task automatic wait_done(output bit got, output int stalls);
      got    = 1'b0;
      stalls = 0;
      for (int n = 0; n < 100; n++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         if (stall) stalls++;
         @(negedge clk);
         #1;
      end
   endtask

   task automatic run_op(input vec_t v);
      bit got;
      int stalls;
      int id;
      @(negedge clk);
      f = v.f;
      a = v.a;
      b = v.b;
      start = 1'b1;
      id = op_id;
      push_exp(v.exp, cyc + v.lat);
      #1;
      wait_done(got, stalls);
      check($sformatf("op%0d done_seen", id), {31'b0, got}, 32'd1);
      if (got) begin
         check($sformatf("op%0d stall_in_done", id), {31'b0, stall}, 32'd0);
         check($sformatf("op%0d stall_cycles", id), stalls, v.lat);
      end
      start = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      int stalls;
      logic [31:0] last_exp;

      //          funct3   rs1           rs2           expected      latency
      tbl[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
      tbl[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
      tbl[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT};
      tbl[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT};
      tbl[4]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
      tbl[5]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h00000000, MUL_LAT};
      tbl[6]  = '{3'b011, 32'h80000000, 32'h00000002, 32'h00000001, MUL_LAT};
      tbl[7]  = '{3'b100, 32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFA, DIV_LAT};
      tbl[8]  = '{3'b110, 32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFE, DIV_LAT};
      tbl[9]  = '{3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT};
      tbl[10] = '{3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT};
      tbl[11] = '{3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT};
      tbl[12] = '{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, DIV_LAT};
      tbl[13] = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT};
      tbl[14] = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, DIV_LAT};
      tbl[15] = '{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, DIV_LAT};
      tbl[16] = '{3'b100, 32'h80000000, 32'h00000002, 32'hC0000000, DIV_LAT};
      tbl[17] = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
      tbl[18] = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
      tbl[19] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
      tbl[20] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      tbl[21] = '{3'b111, 32'h12345678, 32'h00001000, 32'h00000678, DIV_LAT};
      last_exp = tbl[NVEC-1].exp;

      // ---- reset state (i_Start high must not raise o_Stall) ----
      #3;
      rst_n = 1'b0;
      start = 1'b1;
      f = 3'b100;
      a = 32'd9;
      b = 32'd0;
      #4;
      check("reset stall", {31'b0, stall}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset result", res, 32'd0);
      @(negedge clk);
      check("reset held stall", {31'b0, stall}, 32'd0);
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle stall", {31'b0, stall}, 32'd0);

      // ---- table ----
      for (int i = 0; i < NVEC; i++) begin
         run_op(tbl[i]);
      end

      // ---- flush at k+10 ----
      @(negedge clk);
      f = 3'b101;
      a = 32'd1000;
      b = 32'd3;
      start = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      check("flush pre stall", {31'b0, stall}, 32'd1);
      flush = 1'b1;
      start = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush post stall", {31'b0, stall}, 32'd0);
      repeat (40) @(negedge clk);
      #1;
      check("flush result hold", res, last_exp);
      $display("flush sequence end cycle=%0d", cyc);

      // ---- asynchronous reset mid-ITER ----
      @(negedge clk);
      f = 3'b100;
      a = 32'd100;
      b = 32'd7;
      start = 1'b1;
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst stall", {31'b0, stall}, 32'd0);
      check("async rst done", {31'b0, done}, 32'd0);
      check("async rst result", res, 32'd0);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      check("post rst result", res, 32'd0);
      check("post rst stall", {31'b0, stall}, 32'd0);
      $display("reset sequence end cycle=%0d", cyc);

      // ---- back-to-back MUL then DIV with i_Start held ----
      @(negedge clk);
      f = 3'b000;
      a = 32'h00000007;
      b = 32'hFFFFFFFD;
      start = 1'b1;
      push_exp(32'hFFFFFFEB, cyc + MUL_LAT);
      #1;
      wait_done(got, stalls);
      check("b2b mul done_seen", {31'b0, got}, 32'd1);
      check("b2b mul stall_cycles", stalls, MUL_LAT);
      check("b2b mul stall_in_done", {31'b0, stall}, 32'd0);
      f = 3'b100;
      a = 32'hFFFFFFEC;
      b = 32'h00000003;
      push_exp(32'hFFFFFFFA, cyc + 1 + DIV_LAT);
      @(negedge clk);
      #1;
      check("b2b div accept stall", {31'b0, stall}, 32'd1);
      wait_done(got, stalls);
      check("b2b div done_seen", {31'b0, got}, 32'd1);
      check("b2b div stall_cycles", stalls, DIV_LAT);
      start = 1'b0;
      repeat (3) @(negedge clk);

      check("scoreboard drained", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
